// File: rtl/output_image_reg_pkg.sv
// output_image_reg_pkg: shared defaults and encodings for the PLC output-image register.
// Contents: OUT_NUM/ADDR_LEN/PULSE_W defaults, read/write strobe encoding,
//           read-source select encoding.
package output_image_reg_pkg;

  localparam int OUT_NUM_DEF  = 8;
  localparam int ADDR_LEN_DEF = 3;
  localparam int PULSE_W_DEF  = 8;

  // rw strobe encoding
  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  // readSrc encoding
  localparam logic READ_SRC_IMAGE = 1'b0;
  localparam logic READ_SRC_PHYS  = 1'b1;

endpackage

// File: rtl/output_image_reg_if.sv
// output_image_reg_if: execute-stage bit bus, commit/mode controls and output pins.
// master = execute stage side (drives accesses, commit, mode, pulse length);
// slave  = output_image_reg (drives read data, status flags and physical outputs).
interface output_image_reg_if
  import output_image_reg_pkg::*;
#(
  parameter int OUT_NUM  = OUT_NUM_DEF,
  parameter int ADDR_LEN = ADDR_LEN_DEF,
  parameter int PULSE_W  = PULSE_W_DEF
);
  logic                rwEn;
  logic                rw;
  logic [ADDR_LEN-1:0] rwAddr;
  logic                readSrc;
  logic                writeIn;
  logic                readOut;
  logic                readValid;
  logic                addrErr;
  logic                commit;
  logic                modeWrEn;
  logic [OUT_NUM-1:0]  modeIn;
  logic [PULSE_W-1:0]  pulseLen;
  logic [OUT_NUM-1:0]  outputs;
  logic                pulseBusy;

  modport master (
    output rwEn, rw, rwAddr, readSrc, writeIn, commit, modeWrEn, modeIn, pulseLen,
    input  readOut, readValid, addrErr, outputs, pulseBusy
  );

  modport slave (
    input  rwEn, rw, rwAddr, readSrc, writeIn, commit, modeWrEn, modeIn, pulseLen,
    output readOut, readValid, addrErr, outputs, pulseBusy
  );
endinterface

// File: rtl/output_image_reg_out_pulse_ch.sv
// output_image_reg_out_pulse_ch: one physical output channel, latch or pulse mode.
// Ports: clk, reset (async active-low), mode_i (current mode, 1 = pulse), mode_wr_i/mode_new_i
//        (mode reload), commit_i, image_bit_i, pulse_len_i -> out_bit_o, busy_nxt_o (next cnt != 0).
module output_image_reg_out_pulse_ch #(
  parameter int PULSE_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               mode_i,
  input  logic               mode_wr_i,
  input  logic               mode_new_i,
  input  logic               commit_i,
  input  logic               image_bit_i,
  input  logic [PULSE_W-1:0] pulse_len_i,
  output logic               out_bit_o,
  output logic               busy_nxt_o
);

  logic [PULSE_W-1:0] cnt_q, cnt_d;
  logic               out_q, out_d;

  always_comb begin
    cnt_d = cnt_q;
    out_d = out_q;
    if (!mode_i) begin
      if (commit_i) out_d = image_bit_i;
    end else begin
      if (commit_i && image_bit_i && (pulse_len_i != '0)) begin
        // (Re)trigger: reload without dropping the pin, so no low gap.
        out_d = 1'b1;
        cnt_d = pulse_len_i;
      end else if (cnt_q != '0) begin
        // Pulse in flight runs on regardless of a commit with image 0.
        cnt_d = cnt_q - PULSE_W'(1);
        if (cnt_q == PULSE_W'(1)) out_d = 1'b0;
      end else if (commit_i) begin
        out_d = 1'b0;
      end
    end
    // Leaving pulse mode kills the counter but freezes the pin until the next commit.
    if (mode_wr_i && !mode_new_i) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      out_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      out_q <= out_d;
    end
  end

  assign out_bit_o  = out_q;
  assign busy_nxt_o = (cnt_d != '0);

endmodule

// File: rtl/output_image_reg.sv
// output_image_reg: PLC output-image register; shadow image committed to pins at scan end.
// Ports: clk, reset (async active-low), bus (slave modport: bit read/write access,
//        commit, pulse-mode mask load, pulse length, read data/flags, outputs, pulseBusy).
module output_image_reg
  import output_image_reg_pkg::*;
#(
  parameter int OUT_NUM  = OUT_NUM_DEF,
  parameter int ADDR_LEN = ADDR_LEN_DEF,
  parameter int PULSE_W  = PULSE_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  output_image_reg_if.slave     bus
);

  logic [OUT_NUM-1:0] image_q, image_d;
  logic [OUT_NUM-1:0] mode_q, mode_d;
  logic [OUT_NUM-1:0] sel;
  logic [OUT_NUM-1:0] outputs_w;
  logic [OUT_NUM-1:0] busy_nxt;
  logic [OUT_NUM-1:0] rd_src;
  logic               in_range;
  logic               read_out_q, read_out_d;
  logic               read_valid_q, read_valid_d;
  logic               addr_err_q, addr_err_d;
  logic               pulse_busy_q, pulse_busy_d;

  assign in_range = (32'(bus.rwAddr) < OUT_NUM);

  // One-hot bit select; all zero for an out-of-range address.
  for (genvar i = 0; i < OUT_NUM; i++) begin : g_sel
    assign sel[i] = (bus.rwAddr == ADDR_LEN'(i));
  end

  always_comb begin
    image_d = image_q;
    if (bus.rwEn && (bus.rw == RW_WRITE) && in_range)
      image_d = (image_q & ~sel) | (sel & {OUT_NUM{bus.writeIn}});

    read_valid_d = bus.rwEn && (bus.rw == RW_READ);
    addr_err_d   = bus.rwEn && !in_range;
    // Reads see the pre-edge image, so a same-cycle write returns the old bit.
    rd_src       = (bus.readSrc == READ_SRC_PHYS) ? outputs_w : image_q;
    read_out_d   = read_valid_d && in_range && (|(sel & rd_src));

    mode_d       = bus.modeWrEn ? bus.modeIn : mode_q;
    pulse_busy_d = |busy_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      image_q      <= '0;
      mode_q       <= '0;
      read_out_q   <= 1'b0;
      read_valid_q <= 1'b0;
      addr_err_q   <= 1'b0;
      pulse_busy_q <= 1'b0;
    end else begin
      image_q      <= image_d;
      mode_q       <= mode_d;
      read_out_q   <= read_out_d;
      read_valid_q <= read_valid_d;
      addr_err_q   <= addr_err_d;
      pulse_busy_q <= pulse_busy_d;
    end
  end

  // Channels see the old mode and old image, giving commit priority semantics
  // over a coincident mode load or bus write.
  for (genvar i = 0; i < OUT_NUM; i++) begin : g_ch
    output_image_reg_out_pulse_ch #(.PULSE_W(PULSE_W)) u_ch (
      .clk         (clk),
      .reset       (reset),
      .mode_i      (mode_q[i]),
      .mode_wr_i   (bus.modeWrEn),
      .mode_new_i  (bus.modeIn[i]),
      .commit_i    (bus.commit),
      .image_bit_i (image_q[i]),
      .pulse_len_i (bus.pulseLen),
      .out_bit_o   (outputs_w[i]),
      .busy_nxt_o  (busy_nxt[i])
    );
  end

  assign bus.outputs   = outputs_w;
  assign bus.readOut   = read_out_q;
  assign bus.readValid = read_valid_q;
  assign bus.addrErr   = addr_err_q;
  assign bus.pulseBusy = pulse_busy_q;

endmodule

// File: tb/tb_output_image_reg.sv
// tb_output_image_reg: directed scenarios plus random traffic against a time-based reference model.
// Ports: none (instantiates output_image_reg_if and output_image_reg with OUT_NUM=6).
module tb_output_image_reg;
  import output_image_reg_pkg::*;

  localparam int N  = 6;
  localparam int AL = 3;
  localparam int PW = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  output_image_reg_if #(.OUT_NUM(N), .ADDR_LEN(AL), .PULSE_W(PW)) bus ();

  output_image_reg #(.OUT_NUM(N), .ADDR_LEN(AL), .PULSE_W(PW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: a pulse is an absolute end time; the pin is high while
  // cyc < m_pend[i], otherwise it shows the held level m_lat[i].
  bit m_img  [N];
  bit m_mode [N];
  bit m_lat  [N];
  int m_pend [N];
  int cyc = 0;
  bit m_rd, m_rv, m_ae, m_busy;

  function automatic bit m_out(int i, int c);
    return (c < m_pend[i]) ? 1'b1 : m_lat[i];
  endfunction

  function automatic logic [N-1:0] m_outs(int c);
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = m_out(i, c);
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_img[i] = 0; m_mode[i] = 0; m_lat[i] = 0; m_pend[i] = 0;
    end
    m_rd = 0; m_rv = 0; m_ae = 0; m_busy = 0;
  endtask

  task automatic model_edge();
    int n, a, len;
    bit inr;
    n   = cyc + 1;
    a   = int'(bus.rwAddr);
    inr = (a < N);
    len = int'(bus.pulseLen);
    m_rv = bus.rwEn && (bus.rw == RW_READ);
    m_ae = bus.rwEn && !inr;
    m_rd = 0;
    if (m_rv && inr)
      m_rd = (bus.readSrc == READ_SRC_PHYS) ? m_out(a, cyc) : m_img[a];
    if (bus.commit) begin
      for (int i = 0; i < N; i++) begin
        if (!m_mode[i]) m_lat[i] = m_img[i];
        else if (m_img[i] && len != 0) begin
          m_pend[i] = n + len;
          m_lat[i]  = 0;
        end else m_lat[i] = 0;
      end
    end
    if (bus.modeWrEn) begin
      for (int i = 0; i < N; i++) begin
        if (!bus.modeIn[i]) begin
          m_lat[i]  = m_out(i, n);
          m_pend[i] = 0;
        end
        m_mode[i] = bus.modeIn[i];
      end
    end
    if (bus.rwEn && (bus.rw == RW_WRITE) && inr) m_img[a] = bus.writeIn;
    cyc = n;
    m_busy = 0;
    for (int i = 0; i < N; i++) if (m_pend[i] > n) m_busy = 1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.rwEn = 0; bus.rw = RW_WRITE; bus.rwAddr = '0; bus.readSrc = READ_SRC_IMAGE;
    bus.writeIn = 0; bus.commit = 0; bus.modeWrEn = 0; bus.modeIn = '0; bus.pulseLen = '0;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    chk("outputs", 32'(bus.outputs), 32'(m_outs(cyc)));
    chk("pulseBusy", 32'(bus.pulseBusy), 32'(m_busy));
    chk("readValid", 32'(bus.readValid), 32'(m_rv));
    chk("addrErr", 32'(bus.addrErr), 32'(m_ae));
    if (m_rv) chk("readOut", 32'(bus.readOut), 32'(m_rd));
  endtask

  task automatic wr(input int a, input bit v);
    idle();
    bus.rwEn = 1; bus.rw = RW_WRITE; bus.rwAddr = AL'(a); bus.writeIn = v;
  endtask

  task automatic rd(input int a, input logic src);
    idle();
    bus.rwEn = 1; bus.rw = RW_READ; bus.rwAddr = AL'(a); bus.readSrc = src;
  endtask

  initial begin
    int hi;
    idle();
    model_reset();
    reset = 1'b0;
    #12;
    chk("rst_outputs", 32'(bus.outputs), 32'h0);
    chk("rst_busy", 32'(bus.pulseBusy), 32'h0);
    chk("rst_readValid", 32'(bus.readValid), 32'h0);
    chk("rst_addrErr", 32'(bus.addrErr), 32'h0);
    @(negedge clk);
    reset = 1'b1;

    // Latch path
    wr(3, 1); tick();
    wr(5, 1); tick();
    rd(3, READ_SRC_IMAGE); tick();
    chk("latch_read_img3", 32'(bus.readOut), 32'h1);
    chk("latch_pre_commit", 32'(bus.outputs), 32'h0);
    idle(); bus.commit = 1; tick();
    chk("latch_commit", 32'(bus.outputs), 32'h28);

    // Pulse, length 4
    idle(); bus.modeWrEn = 1; bus.modeIn = N'(1); tick();
    wr(0, 1); tick();
    idle(); bus.commit = 1; bus.pulseLen = PW'(4); tick();
    hi = int'(bus.outputs[0]);
    idle();
    for (int k = 0; k < 8; k++) begin
      tick();
      if (bus.outputs[0]) hi++;
    end
    chk("pulse4_high_cycles", 32'(hi), 32'd4);
    idle(); bus.commit = 1; bus.pulseLen = '0; tick();
    chk("pulse0_out0", 32'(bus.outputs[0]), 32'h0);
    chk("pulse0_busy", 32'(bus.pulseBusy), 32'h0);

    // Retrigger: length 5, recommit 3 cycles later
    idle(); bus.commit = 1; bus.pulseLen = PW'(5); tick();
    hi = int'(bus.outputs[0]);
    idle();
    for (int k = 0; k < 2; k++) begin
      tick();
      if (bus.outputs[0]) hi++;
    end
    idle(); bus.commit = 1; bus.pulseLen = PW'(5); tick();
    if (bus.outputs[0]) hi++;
    idle();
    for (int k = 0; k < 10; k++) begin
      tick();
      if (bus.outputs[0]) hi++;
    end
    chk("retrigger_high_cycles", 32'(hi), 32'd8);

    // Write and commit together
    wr(2, 1); bus.commit = 1; tick();
    chk("simul_out2_old", 32'(bus.outputs[2]), 32'h0);
    idle(); bus.commit = 1; tick();
    chk("simul_out2_new", 32'(bus.outputs[2]), 32'h1);

    // Out of range
    wr(7, 1); tick();
    chk("range_wr_addrErr", 32'(bus.addrErr), 32'h1);
    rd(6, READ_SRC_IMAGE); tick();
    chk("range_rd_readOut", 32'(bus.readOut), 32'h0);
    chk("range_rd_readValid", 32'(bus.readValid), 32'h1);
    chk("range_rd_addrErr", 32'(bus.addrErr), 32'h1);
    rd(5, READ_SRC_PHYS); tick();
    chk("rd_phys5", 32'(bus.readOut), 32'h1);

    // Reset mid-pulse
    idle(); bus.commit = 1; bus.pulseLen = PW'(20); tick();
    idle(); tick(); tick();
    #3 reset = 1'b0;
    #1;
    chk("async_rst_outputs", 32'(bus.outputs), 32'h0);
    chk("async_rst_busy", 32'(bus.pulseBusy), 32'h0);
    chk("async_rst_readValid", 32'(bus.readValid), 32'h0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    rd(3, READ_SRC_IMAGE); tick();
    chk("rst_image_cleared", 32'(bus.readOut), 32'h0);

    // Random traffic
    for (int k = 0; k < 600; k++) begin
      bus.rwEn     = 1'($urandom_range(0, 1));
      bus.rw       = 1'($urandom_range(0, 1));
      bus.rwAddr   = AL'($urandom_range(0, 7));
      bus.readSrc  = 1'($urandom_range(0, 1));
      bus.writeIn  = 1'($urandom_range(0, 1));
      bus.commit   = ($urandom_range(0, 4) == 0);
      bus.modeWrEn = ($urandom_range(0, 19) == 0);
      bus.modeIn   = N'($urandom);
      bus.pulseLen = PW'($urandom_range(0, 6));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
